fp_div_seq: RTL and testbench

Iterative single-precision floating-point divider, computing fp_Z = fp_X / fp_Y. It is the inverse-direction companion to the existing combinational FP multiplier in the ALU.
- Algorithm: radix-2 restoring division on the significands, with a start/done handshake.
- Conventions shared with the multiplier: flush-to-zero of subnormals, the same r_mode encoding, the same ovrf/udrf flag semantics.

---
 rtl/fp_div_pkg.sv | 26 ++
 rtl/fp_div_seq_if.sv | 24 ++
 rtl/fp_div_round.sv | 56 +++++
 rtl/fp_div_seq.sv | 185 ++++++++++++++++++
 tb/tb_fp_div_seq.sv | 303 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fp_div_pkg.sv
// Shared types and constants for the sequential single-precision divider.
package fp_div_pkg;

  typedef enum logic [2:0] {
    RNE = 3'b000,
    RTZ = 3'b001,
    RDN = 3'b010,
    RUP = 3'b011,
    RMM = 3'b100
  } r_mode_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SPECIAL,
    S_DIVIDE,
    S_ROUND,
    S_DONE
  } state_e;

  localparam int unsigned BIAS    = 127;
  localparam logic [31:0] QNAN    = 32'h7FC00000;
  localparam logic [30:0] MAXF    = 31'h7F7FFFFF;
  localparam logic [7:0]  EXP_INF = 8'hFF;
  localparam logic [30:0] INF_MAG = {EXP_INF, 23'd0};

endpackage

// File: rtl/fp_div_seq_if.sv
// Operand/result handshake bundle between a requester and fp_div_seq.
interface fp_div_seq_if;
  logic        start;
  logic [31:0] fp_X;
  logic [31:0] fp_Y;
  logic [2:0]  r_mode;
  logic        busy;
  logic        done;
  logic [31:0] fp_Z;
  logic        ovrf;
  logic        udrf;
  logic        dz;
  logic        nv;

  modport master (
    output start, fp_X, fp_Y, r_mode,
    input  busy, done, fp_Z, ovrf, udrf, dz, nv
  );

  modport slave (
    input  start, fp_X, fp_Y, r_mode,
    output busy, done, fp_Z, ovrf, udrf, dz, nv
  );
endinterface

// File: rtl/fp_div_round.sv
// Rounds the 26-bit quotient (24 significand + guard + round) plus sticky,
// applies the rounding carry to the exponent and resolves overflow/underflow.
module fp_div_round
  import fp_div_pkg::*;
(
  input  logic              sign,
  input  logic signed [9:0] eZ,
  input  logic [25:0]       q,
  input  logic              sticky,
  input  r_mode_e           r_mode,
  output logic [30:0]       fp_Z,
  output logic              ovrf,
  output logic              udrf
);

  logic              inexact;
  logic              inc;
  logic [32:0]       full;
  logic signed [9:0] e;
  logic [22:0]       frac;

  always_comb begin
    inexact = q[1] | q[0] | sticky;
    case (r_mode)
      RTZ:     inc = 1'b0;
      RDN:     inc = sign & inexact;
      RUP:     inc = ~sign & inexact;
      RMM:     inc = q[1];
      default: inc = q[1] & (q[0] | sticky | q[2]);
    endcase

    // Hidden bit q[25] lands in the exponent field, so (eZ-1) restores eZ and a
    // rounding carry out of the significand bumps the exponent automatically.
    full = {eZ - 10'sd1, 23'd0} + {9'd0, q[25:2]} + {32'd0, inc};
    e    = $signed(full[32:23]);
    frac = full[22:0];

    ovrf = 1'b0;
    udrf = 1'b0;
    fp_Z = '0;
    if (e >= 10'sd255) begin
      ovrf = 1'b1;
      case (r_mode)
        RTZ:     fp_Z = MAXF;
        RDN:     fp_Z = sign ? INF_MAG : MAXF;
        RUP:     fp_Z = sign ? MAXF : INF_MAG;
        default: fp_Z = INF_MAG;
      endcase
    end else if (e <= 10'sd0) begin
      udrf = 1'b1;
    end else begin
      fp_Z = {e[7:0], frac};
    end
  end

endmodule

// File: rtl/fp_div_seq.sv
// Iterative binary32 divider (radix-2 restoring), start/done handshake.
// Define FP_DIV_EARLY_TERM_EN to stop dividing once the remainder reaches zero.
module fp_div_seq
  import fp_div_pkg::*;
#(
  parameter int unsigned ITER = 26
) (
  input  logic         clk,
  input  logic         rst,
  fp_div_seq_if.slave  bus
);

  localparam int unsigned CW = $clog2(ITER);

  state_e            state_q;
  logic [31:0]       x_q, y_q;
  r_mode_e           rmode_q;
  logic              sign_q;
  logic signed [9:0] ez_q;
  logic [23:0]       my_q;
  logic [25:0]       r_q, r_d;
  logic [ITER-1:0]   q_q, q_d;
  logic [CW-1:0]     cnt_q;

  logic              busy_q, done_q, ovrf_q, udrf_q, dz_q, nv_q;
  logic [31:0]       z_q;

  logic [7:0]        ex_in, ey_in;
  logic [23:0]       mx_in, my_in;
  logic              adj_in, special_in;
  logic [25:0]       r_in;
  logic signed [9:0] ez_in;

  always_comb begin
    ex_in      = bus.fp_X[30:23];
    ey_in      = bus.fp_Y[30:23];
    mx_in      = {1'b1, bus.fp_X[22:0]};
    my_in      = {1'b1, bus.fp_Y[22:0]};
    adj_in     = mx_in < my_in;
    special_in = (ex_in == 8'd0) || (ex_in == EXP_INF) ||
                 (ey_in == 8'd0) || (ey_in == EXP_INF);
    r_in       = adj_in ? {1'b0, mx_in, 1'b0} : {2'b00, mx_in};
    ez_in      = $signed({2'b00, ex_in}) - $signed({2'b00, ey_in})
               + $signed(10'(BIAS)) - $signed({9'd0, adj_in});
  end

  logic        xs_z, xs_i, xs_n, ys_z, ys_i, ys_n, sp_s;
  logic [31:0] spec_z;
  logic        spec_dz, spec_nv;

  always_comb begin
    xs_z = x_q[30:23] == 8'd0;
    xs_i = (x_q[30:23] == EXP_INF) && (x_q[22:0] == 23'd0);
    xs_n = (x_q[30:23] == EXP_INF) && (x_q[22:0] != 23'd0);
    ys_z = y_q[30:23] == 8'd0;
    ys_i = (y_q[30:23] == EXP_INF) && (y_q[22:0] == 23'd0);
    ys_n = (y_q[30:23] == EXP_INF) && (y_q[22:0] != 23'd0);
    sp_s = x_q[31] ^ y_q[31];

    spec_z  = {sp_s, 31'd0};
    spec_dz = 1'b0;
    spec_nv = 1'b0;
    if (xs_n || ys_n || (xs_z && ys_z) || (xs_i && ys_i)) begin
      spec_z  = QNAN;
      spec_nv = 1'b1;
    end else if (xs_i) begin
      spec_z = {sp_s, INF_MAG};
    end else if (ys_z) begin
      spec_z  = {sp_s, INF_MAG};
      spec_dz = 1'b1;
    end
  end

  logic        ge;
  logic [25:0] sub;

  always_comb begin
    ge  = r_q >= {2'b00, my_q};
    sub = r_q - {2'b00, my_q};
    r_d = (ge ? sub : r_q) << 1;
    q_d = {q_q[ITER-2:0], ge};
  end

  logic [30:0] rnd_mag;
  logic        rnd_ovrf, rnd_udrf;

  fp_div_round u_round (
    .sign   (sign_q),
    .eZ     (ez_q),
    .q      (q_q),
    .sticky (|r_q),
    .r_mode (rmode_q),
    .fp_Z   (rnd_mag),
    .ovrf   (rnd_ovrf),
    .udrf   (rnd_udrf)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      z_q     <= '0;
      ovrf_q  <= 1'b0;
      udrf_q  <= 1'b0;
      dz_q    <= 1'b0;
      nv_q    <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      rmode_q <= RNE;
      sign_q  <= 1'b0;
      ez_q    <= '0;
      my_q    <= '0;
      r_q     <= '0;
      q_q     <= '0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            x_q     <= bus.fp_X;
            y_q     <= bus.fp_Y;
            rmode_q <= r_mode_e'(bus.r_mode);
            sign_q  <= bus.fp_X[31] ^ bus.fp_Y[31];
            ez_q    <= ez_in;
            my_q    <= my_in;
            r_q     <= r_in;
            q_q     <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            ovrf_q  <= 1'b0;
            udrf_q  <= 1'b0;
            dz_q    <= 1'b0;
            nv_q    <= 1'b0;
            state_q <= special_in ? S_SPECIAL : S_DIVIDE;
          end
        end
        S_SPECIAL: begin
          z_q     <= spec_z;
          dz_q    <= spec_dz;
          nv_q    <= spec_nv;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= S_DONE;
        end
        S_DIVIDE: begin
          r_q   <= r_d;
          q_q   <= q_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CW'(ITER - 1)) begin
            state_q <= S_ROUND;
          end
`ifdef FP_DIV_EARLY_TERM_EN
          else if (r_d == '0) begin
            q_q     <= q_d << (CW'(ITER - 1) - cnt_q);
            state_q <= S_ROUND;
          end
`endif
        end
        S_ROUND: begin
          z_q     <= {sign_q, rnd_mag};
          ovrf_q  <= rnd_ovrf;
          udrf_q  <= rnd_udrf;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= S_DONE;
        end
        S_DONE: begin
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.fp_Z = z_q;
  assign bus.ovrf = ovrf_q;
  assign bus.udrf = udrf_q;
  assign bus.dz   = dz_q;
  assign bus.nv   = nv_q;

endmodule

// File: tb/tb_fp_div_seq.sv
// Bench for fp_div_seq: directed vector table, random operands against an
// exact integer-division reference, plus re-start and mid-operation reset.
module tb_fp_div_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;

  fp_div_seq_if bus ();

  fp_div_seq #(.ITER(26)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  localparam logic [3:0] F_NONE = 4'b0000;
  localparam logic [3:0] F_NV   = 4'b1000;
  localparam logic [3:0] F_DZ   = 4'b0100;
  localparam logic [3:0] F_UF   = 4'b0010;
  localparam logic [3:0] F_OF   = 4'b0001;

  typedef struct {
    logic [31:0] x;
    logic [31:0] y;
    logic [2:0]  rm;
    logic [31:0] z;
    logic [3:0]  fl;
    int          lat;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_lat(input string name, input int lat, input int exp);
    logic ok;
    checks++;
`ifdef FP_DIV_EARLY_TERM_EN
    ok = (exp == 2) ? (lat == 2) : (lat > 2 && lat <= exp);
`else
    ok = (lat == exp);
`endif
    if (!ok) begin
      errors++;
      $display("FAIL %s: done at cycle %0d expected %0d", name, lat, exp);
    end
  endtask

  function automatic logic is_special(input logic [31:0] v);
    return (v[30:23] == 8'd0) || (v[30:23] == 8'hFF);
  endfunction

  // Reference: exact quotient from 64-bit integer division, rounded by value.
  function automatic logic [35:0] ref_div(input logic [31:0] x, input logic [31:0] y,
                                          input logic [2:0] rm);
    logic s, xz, xi, xn, yz, yi, yn, inc, inx, ab, tie;
    int ex, ey, e, p;
    longint unsigned mx, my, n, rem, keep, drop, half;
    s  = x[31] ^ y[31];
    ex = int'(x[30:23]);
    ey = int'(y[30:23]);
    xz = (ex == 0);
    yz = (ey == 0);
    xi = (ex == 255) && (x[22:0] == 23'd0);
    yi = (ey == 255) && (y[22:0] == 23'd0);
    xn = (ex == 255) && (x[22:0] != 23'd0);
    yn = (ey == 255) && (y[22:0] != 23'd0);
    if (xn || yn || (xz && yz) || (xi && yi)) return {F_NV, 32'h7FC00000};
    if (xi) return {F_NONE, s, 31'h7F800000};
    if (yz) return {F_DZ, s, 31'h7F800000};
    if (xz || yi) return {F_NONE, s, 31'd0};
    mx   = 64'h800000 | 64'(x[22:0]);
    my   = 64'h800000 | 64'(y[22:0]);
    n    = (mx << 40) / my;
    rem  = (mx << 40) % my;
    e    = ex - ey + 127;
    if ((n >> 40) != 0) p = 40;
    else begin
      p = 39;
      e = e - 1;
    end
    keep = n >> (p - 23);
    drop = n & ((64'd1 << (p - 23)) - 1);
    half = 64'd1 << (p - 24);
    inx  = (drop != 0) || (rem != 0);
    ab   = (drop > half) || ((drop == half) && (rem != 0));
    tie  = (drop == half) && (rem == 0);
    case (rm)
      3'd1:    inc = 1'b0;
      3'd2:    inc = s & inx;
      3'd3:    inc = !s & inx;
      3'd4:    inc = drop >= half;
      default: inc = ab || (tie && keep[0]);
    endcase
    keep = keep + 64'(inc);
    if (keep == (64'd1 << 24)) begin
      keep = 64'd1 << 23;
      e    = e + 1;
    end
    if (e >= 255) begin
      case (rm)
        3'd1:    return {F_OF, s, 31'h7F7FFFFF};
        3'd2:    return {F_OF, s, s ? 31'h7F800000 : 31'h7F7FFFFF};
        3'd3:    return {F_OF, s, s ? 31'h7F7FFFFF : 31'h7F800000};
        default: return {F_OF, s, 31'h7F800000};
      endcase
    end
    if (e <= 0) return {F_UF, s, 31'd0};
    return {F_NONE, s, e[7:0], keep[22:0]};
  endfunction

  function automatic logic [31:0] rnd_op();
    logic [31:0] v;
    int k;
    v = $urandom;
    k = $urandom_range(0, 19);
    case (k)
      0: v[30:23] = 8'd0;
      1: begin
        v[30:23] = 8'hFF;
        if ($urandom_range(0, 1) == 1) v[22:0] = '0;
      end
      2: v[30:23] = 8'($urandom_range(1, 6));
      3: v[30:23] = 8'($urandom_range(249, 254));
      4: begin
        v[30:23] = 8'($urandom_range(100, 150));
        v[22:0]  = {v[22:20], 20'd0};
      end
      default: v[30:23] = 8'($urandom_range(1, 254));
    endcase
    return v;
  endfunction

  task automatic run_op(input logic [31:0] x, input logic [31:0] y, input logic [2:0] rm,
                        output logic [31:0] z, output logic [3:0] fl, output int lat);
    @(negedge clk);
    bus.fp_X   = x;
    bus.fp_Y   = y;
    bus.r_mode = rm;
    bus.start  = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    chk("busy_after_start", {31'd0, bus.busy}, 32'd1);
    lat = -1;
    z   = 'x;
    fl  = 'x;
    for (int c = 1; c <= 100; c++) begin
      if (bus.done) begin
        lat = c;
        z   = bus.fp_Z;
        fl  = {bus.nv, bus.dz, bus.udrf, bus.ovrf};
        break;
      end
      @(negedge clk);
    end
  endtask

  vec_t        vt[$];
  logic [31:0] z;
  logic [3:0]  fl;
  int          lat;

  initial begin
    logic [31:0] x, y;
    logic [2:0]  rm;
    logic [35:0] exp;
    int          ndone;

    bus.start  = 1'b0;
    bus.fp_X   = '0;
    bus.fp_Y   = '0;
    bus.r_mode = '0;

    vt.push_back('{32'h40C00000, 32'h40000000, 3'd0, 32'h40400000, F_NONE, 28});
    vt.push_back('{32'h3F800000, 32'h40400000, 3'd0, 32'h3EAAAAAB, F_NONE, 28});
    vt.push_back('{32'h3F800000, 32'h40400000, 3'd1, 32'h3EAAAAAA, F_NONE, 28});
    vt.push_back('{32'h3F800000, 32'h40400000, 3'd3, 32'h3EAAAAAB, F_NONE, 28});
    vt.push_back('{32'h3F800000, 32'h40400000, 3'd2, 32'h3EAAAAAA, F_NONE, 28});
    vt.push_back('{32'h3F800000, 32'h40400000, 3'd4, 32'h3EAAAAAB, F_NONE, 28});
    vt.push_back('{32'h3F800000, 32'h40400000, 3'd7, 32'h3EAAAAAB, F_NONE, 28});
    vt.push_back('{32'hBF800000, 32'h40400000, 3'd2, 32'hBEAAAAAB, F_NONE, 28});
    vt.push_back('{32'hBF800000, 32'h40400000, 3'd3, 32'hBEAAAAAA, F_NONE, 28});
    vt.push_back('{32'h3F800000, 32'hBF800000, 3'd0, 32'hBF800000, F_NONE, 28});
    vt.push_back('{32'h3F800000, 32'h00000000, 3'd0, 32'h7F800000, F_DZ,   2});
    vt.push_back('{32'h00000000, 32'h00000000, 3'd0, 32'h7FC00000, F_NV,   2});
    vt.push_back('{32'h7F7FFFFF, 32'h00800000, 3'd0, 32'h7F800000, F_OF,   28});
    vt.push_back('{32'h7F7FFFFF, 32'h00800000, 3'd1, 32'h7F7FFFFF, F_OF,   28});
    vt.push_back('{32'h7F7FFFFF, 32'h00800000, 3'd2, 32'h7F7FFFFF, F_OF,   28});
    vt.push_back('{32'h7F7FFFFF, 32'h00800000, 3'd3, 32'h7F800000, F_OF,   28});
    vt.push_back('{32'h7F7FFFFF, 32'h00800000, 3'd4, 32'h7F800000, F_OF,   28});
    vt.push_back('{32'hFF7FFFFF, 32'h00800000, 3'd2, 32'hFF800000, F_OF,   28});
    vt.push_back('{32'hFF7FFFFF, 32'h00800000, 3'd3, 32'hFF7FFFFF, F_OF,   28});
    vt.push_back('{32'h7F7FFFFF, 32'h3F800000, 3'd0, 32'h7F7FFFFF, F_NONE, 28});
    vt.push_back('{32'h00800000, 32'h40000000, 3'd0, 32'h00000000, F_UF,   28});
    vt.push_back('{32'h00800000, 32'h3F800000, 3'd0, 32'h00800000, F_NONE, 28});
    vt.push_back('{32'h00400000, 32'h3F800000, 3'd0, 32'h00000000, F_NONE, 2});
    vt.push_back('{32'h7F800000, 32'h7F800000, 3'd0, 32'h7FC00000, F_NV,   2});
    vt.push_back('{32'h7FC00001, 32'h3F800000, 3'd0, 32'h7FC00000, F_NV,   2});
    vt.push_back('{32'hC0000000, 32'h7F800000, 3'd0, 32'h80000000, F_NONE, 2});
    vt.push_back('{32'hFF800000, 32'h40000000, 3'd0, 32'hFF800000, F_NONE, 2});
    vt.push_back('{32'h7F800000, 32'h00000000, 3'd0, 32'h7F800000, F_NONE, 2});
    vt.push_back('{32'h80000000, 32'h3F800000, 3'd0, 32'h80000000, F_NONE, 2});

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("reset_busy", {31'd0, bus.busy}, 32'd0);
    chk("reset_done", {31'd0, bus.done}, 32'd0);
    chk("reset_fpZ", bus.fp_Z, 32'd0);
    chk("reset_flags", {28'd0, bus.nv, bus.dz, bus.udrf, bus.ovrf}, 32'd0);

    foreach (vt[i]) begin
      run_op(vt[i].x, vt[i].y, vt[i].rm, z, fl, lat);
      chk($sformatf("vec%0d_z", i), z, vt[i].z);
      chk($sformatf("vec%0d_flags", i), {28'd0, fl}, {28'd0, vt[i].fl});
      chk_lat($sformatf("vec%0d_latency", i), lat, vt[i].lat);
    end

    for (int i = 0; i < 80; i++) begin
      x   = rnd_op();
      y   = rnd_op();
      rm  = 3'($urandom_range(0, 7));
      exp = ref_div(x, y, rm);
      run_op(x, y, rm, z, fl, lat);
      chk($sformatf("rnd%0d_z(%h/%h rm%0d)", i, x, y, rm), z, exp[31:0]);
      chk($sformatf("rnd%0d_flags", i), {28'd0, fl}, {28'd0, exp[35:32]});
      chk_lat($sformatf("rnd%0d_latency", i), lat,
              (is_special(x) || is_special(y)) ? 2 : 28);
    end

    // start re-pulsed with a special operand pair while dividing
    @(negedge clk);
    bus.fp_X   = 32'h40C00000;
    bus.fp_Y   = 32'h40000000;
    bus.r_mode = 3'd0;
    bus.start  = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    lat = -1;
    z   = 'x;
    fl  = 'x;
    for (int c = 1; c <= 100; c++) begin
      if (c == 5) begin
        bus.fp_X   = 32'h3F800000;
        bus.fp_Y   = 32'h00000000;
        bus.r_mode = 3'd1;
        bus.start  = 1'b1;
      end
      if (c == 9) bus.start = 1'b0;
      if (bus.done) begin
        lat = c;
        z   = bus.fp_Z;
        fl  = {bus.nv, bus.dz, bus.udrf, bus.ovrf};
        break;
      end
      @(negedge clk);
    end
    chk("restart_z", z, 32'h40400000);
    chk("restart_flags", {28'd0, fl}, 32'd0);
    chk_lat("restart_latency", lat, 28);
    @(negedge clk);
    chk("restart_done_pulse", {31'd0, bus.done}, 32'd0);
    chk("restart_idle_busy", {31'd0, bus.busy}, 32'd0);

    // reset asserted around iteration 10
    @(negedge clk);
    bus.fp_X   = 32'h3F800000;
    bus.fp_Y   = 32'h40400000;
    bus.r_mode = 3'd0;
    bus.start  = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", {31'd0, bus.busy}, 32'd0);
    chk("abort_done", {31'd0, bus.done}, 32'd0);
    chk("abort_fpZ", bus.fp_Z, 32'd0);
    ndone = 0;
    for (int c = 0; c < 40; c++) begin
      if (bus.done) ndone++;
      @(negedge clk);
    end
    chk("abort_no_done", 32'(ndone), 32'd0);
    run_op(32'h40C00000, 32'h40000000, 3'd0, z, fl, lat);
    chk("after_abort_z", z, 32'h40400000);
    chk_lat("after_abort_latency", lat, 28);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
